cam_match_reader: RTL and testbench
===================================

# cam_match_reader

Read-out engine for the associative processor's CAM array. It takes a snapshot of the array's per-row match vector (`tag_row`) after a compare pass and walks the set bits lowest-index first. For each match it drives the array's row read address and captures the row word. Each matched row is returned as one beat on a valid/ready output stream, tagged with its row index. It sits between the CAM array and the result-collection logic.

## Interface
- `DATA_WIDTH`, 8, bits per CAM row word
- `DATA_DEPTH`, 16, number of CAM rows (tag vector width)
- `ADDR_WIDTH_CAM`, 8, row address width; must satisfy 2^ADDR_WIDTH_CAM ≥ DATA_DEPTH
- `clk`  in  1  clock, rising edge
- `rstIn`  in  1  reset, asynchronous, active-high
- `start`  in  1  latch `tag_row` and begin scan; ignored while `busy`
- `tag_row`  in  DATA_DEPTH  match vector from the array; bit i = row i matched
- `addr_output_Row`  out  ADDR_WIDTH_CAM  row read address to the array
- `Q_out_row`  in  DATA_WIDTH  row word returned by the array
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  downstream accepts beat
- `m_data`  out  DATA_WIDTH  captured row word
- `m_addr`  out  ADDR_WIDTH_CAM  row index of the beat
- `m_last`  out  1  final match of this scan
- `busy`  out  1  scan in progress; the integrator holds the array in RowxRow mode while high
- `done`  out  1  one-cycle pulse at end of scan
- `no_match`  out  1  registered; set when the last scan found zero matches
- `match_count`  out  ADDR_WIDTH_CAM+1  matches delivered in the current or last scan

## Operation
- States: IDLE, ISSUE, CAPTURE, OUT, DONE.
- IDLE:
  - If `start` and the snapshot is nonzero: latch `tag_row` into `pend`, clear `match_count` and `no_match`, go to ISSUE.
  - If `start` and the snapshot is zero: set `no_match`, go to DONE.
- ISSUE: register `addr_output_Row` = index of the lowest set bit of `pend`, go to CAPTURE.
- CAPTURE: sample `Q_out_row` into `m_data` and copy the address into `m_addr`; clear that bit in `pend`; set `m_last` = (`pend` is now zero); go to OUT.
- OUT: hold `m_valid`=1.
  - On `m_valid & m_ready`: increment `match_count`, drop `m_valid`.
  - After the handshake, go to ISSUE if `m_last`=0, else go to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0 from the next cycle, return to IDLE.
- `busy` = state ≠ IDLE.
- Changes on `tag_row` after the snapshot have no effect until the next `start`.
- `start` while `busy` is dropped (not queued).
- `match_count` saturates at DATA_DEPTH; it cannot exceed it by construction.

## Timing
- Reset values: `addr_output_Row`=0, `m_valid`=0, `m_data`=0, `m_addr`=0, `m_last`=0, `busy`=0, `done`=0, `no_match`=0, `match_count`=0, `pend`=0, state IDLE.
- `start` sampled at edge k:
  - ISSUE in cycle k+1, with `addr_output_Row` valid in that cycle.
  - CAPTURE in k+2; the array read path is treated as one full cycle.
  - `m_valid` first high in k+3.
- With `m_ready` held high: one beat every 3 cycles.
- `done` goes high the cycle after the last handshake.
- Zero-match scan: `done` high in k+1, `no_match`=1 from k+1.
- Backpressure: while `m_valid`=1 and `m_ready`=0, `m_data`, `m_addr` and `m_last` are stable and `m_valid` does not drop.
- `m_ready` outside OUT is ignored.
- `rstIn` mid-scan: all outputs return to reset values immediately (asynchronous). The partial scan is discarded and no `done` is issued.
- `start` coincident with the final handshake is dropped, since state is still OUT.

## Configuration
- `CAM_RD_FIRST_MATCH_EN`
- Defined:
  - The scan stops after the lowest-index match.
  - `m_last`=1 on the first beat, `match_count` ≤ 1.
  - `pend` reduces to a found flag plus index.
- Undefined: all matches are delivered as described above.

## Structure
- Package `cam_pkg`:
  - state enum `cam_rd_state_t`
  - default DATA_WIDTH/DATA_DEPTH/ADDR_WIDTH_CAM constants
  - mode codes RowxRow=1, ColxCol=2, COPY_B=3, COPY_R=4, COPY_A=5, shared with the array
- Sub-module `cam_prio_enc`: combinational lowest-set-bit encoder over DATA_DEPTH, producing index and found flag. Instantiated once on `pend`.

## Test plan
- Empty tag: `tag_row`=16'h0000, pulse `start`. `done` pulses 1 cycle later, `no_match`=1, no `m_valid`, `match_count`=0.
- Two matches, no backpressure: `tag_row`=16'h0024, row2=8'hA5, row5=8'h3C, `m_ready`=1.
  - Beats are (addr 2, 8'hA5, last 0) then (addr 5, 8'h3C, last 1).
  - First `m_valid` at start+3; `match_count`=2; `done` one cycle after the second handshake.
- Backpressure: same stimulus, `m_ready` low for 4 cycles on the first beat. `m_valid` is held and data/addr are stable; the sequence is otherwise unchanged.
- Snapshot isolation and busy: change `tag_row` to 16'hFFFF and pulse `start` again during the scan. Only rows 2 and 5 are delivered and the second `start` is ignored.
- Async reset: assert `rstIn` in OUT of the first beat. All outputs go to zero immediately and no `done` is issued. After release, a new `start` with 16'h0001 delivers row 0 with `m_last`=1.
- `CAM_RD_FIRST_MATCH_EN` build: `tag_row`=16'h8081 gives a single beat with addr 0, `m_last`=1, `match_count`=1.

Source files
------------

// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the associative processor CAM read-out path.
//   - cam_rd_state_t : state encoding of the cam_match_reader scan FSM
//   - CAM_DATA_WIDTH / CAM_DATA_DEPTH / CAM_ADDR_WIDTH : default geometry
//   - CAM_MODE_* : array operating-mode codes, shared with the CAM array
// No ports (package).
// -----------------------------------------------------------------------------
package cam_pkg;

  // Default array geometry
  localparam int CAM_DATA_WIDTH = 8;   // bits per row word
  localparam int CAM_DATA_DEPTH = 16;  // number of rows / tag vector width
  localparam int CAM_ADDR_WIDTH = 8;   // row address width

  // Array mode codes; the integrator selects ROWXROW while the reader is busy
  localparam logic [2:0] CAM_MODE_ROWXROW = 3'd1;
  localparam logic [2:0] CAM_MODE_COLXCOL = 3'd2;
  localparam logic [2:0] CAM_MODE_COPY_B  = 3'd3;
  localparam logic [2:0] CAM_MODE_COPY_R  = 3'd4;
  localparam logic [2:0] CAM_MODE_COPY_A  = 3'd5;

  // Scan FSM states
  typedef enum logic [2:0] {
    CAM_RD_IDLE    = 3'd0,
    CAM_RD_ISSUE   = 3'd1,
    CAM_RD_CAPTURE = 3'd2,
    CAM_RD_OUT     = 3'd3,
    CAM_RD_DONE    = 3'd4
  } cam_rd_state_t;

endpackage : cam_pkg

// File: rtl/cam_prio_enc.sv
// -----------------------------------------------------------------------------
// cam_prio_enc
// Combinational lowest-set-bit priority encoder.
// Ports:
//   i_vec   in  DEPTH  input vector
//   o_idx   out IDX_W  index of the lowest set bit (0 when none set)
//   o_found out 1      at least one bit of i_vec is set
// -----------------------------------------------------------------------------
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int DEPTH = CAM_DATA_DEPTH,
  parameter int IDX_W = CAM_ADDR_WIDTH
) (
  input  logic [DEPTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule : cam_prio_enc

// File: rtl/cam_match_reader.sv
// -----------------------------------------------------------------------------
// cam_match_reader
// Read-out engine for the CAM array. Snapshots the per-row match vector on
// start, then walks the set bits lowest index first: drives the row read
// address, captures the returned row word and presents it as one beat on a
// valid/ready stream tagged with its row index.
//
// Build option:
//   CAM_RD_FIRST_MATCH_EN - when defined, the scan stops after the lowest-index
//   match (single beat with m_last=1); the pending vector shrinks to a found
//   flag plus index.
//
// Ports:
//   clk             in  1               clock, rising edge
//   rstIn           in  1               asynchronous active-high reset
//   start           in  1               snapshot tag_row and scan; ignored while busy
//   tag_row         in  DATA_DEPTH      match vector, bit i = row i matched
//   addr_output_Row out ADDR_WIDTH_CAM  row read address to the array
//   Q_out_row       in  DATA_WIDTH      row word returned by the array
//   m_valid         out 1               output beat valid
//   m_ready         in  1               downstream accepts beat
//   m_data          out DATA_WIDTH      captured row word
//   m_addr          out ADDR_WIDTH_CAM  row index of the beat
//   m_last          out 1               final match of this scan
//   busy            out 1               scan in progress (state != IDLE)
//   done            out 1               one-cycle pulse at end of scan
//   no_match        out 1               last scan found zero matches
//   match_count     out ADDR_WIDTH_CAM+1 matches delivered in current/last scan
//
// Output stream handshake: a beat transfers on a rising edge where
// m_valid & m_ready are both high; once m_valid rises it stays high, and
// m_data / m_addr / m_last stay stable, until that transfer happens.
// -----------------------------------------------------------------------------
module cam_match_reader
  import cam_pkg::*;
#(
  parameter int DATA_WIDTH     = CAM_DATA_WIDTH,
  parameter int DATA_DEPTH     = CAM_DATA_DEPTH,
  parameter int ADDR_WIDTH_CAM = CAM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic                      start,
  input  logic [DATA_DEPTH-1:0]     tag_row,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row,
  input  logic [DATA_WIDTH-1:0]     Q_out_row,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [ADDR_WIDTH_CAM-1:0] m_addr,
  output logic                      m_last,
  output logic                      busy,
  output logic                      done,
  output logic                      no_match,
  output logic [ADDR_WIDTH_CAM:0]   match_count
);

  localparam logic [ADDR_WIDTH_CAM:0] MAX_COUNT = (ADDR_WIDTH_CAM + 1)'(DATA_DEPTH);

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  cam_rd_state_t               r_state;
  cam_rd_state_t               w_state_next;

  logic [ADDR_WIDTH_CAM-1:0]   r_addr;
  logic                        r_m_valid;
  logic [DATA_WIDTH-1:0]       r_m_data;
  logic [ADDR_WIDTH_CAM-1:0]   r_m_addr;
  logic                        r_m_last;
  logic                        r_no_match;
  logic [ADDR_WIDTH_CAM:0]     r_match_count;

  logic [DATA_DEPTH-1:0]       w_enc_in;
  logic [ADDR_WIDTH_CAM-1:0]   w_enc_idx;
  logic                        w_enc_found;

  logic                        w_busy;
  logic                        w_done;
  logic                        w_start_hit;   // accepted start, snapshot nonzero
  logic                        w_start_empty; // accepted start, snapshot zero
  logic                        w_capture;
  logic                        w_handshake;
  logic                        w_capture_last;
  logic [ADDR_WIDTH_CAM-1:0]   w_capture_addr;

  // ---------------------------------------------------------------------------
  // Pending-match storage
  // ---------------------------------------------------------------------------
`ifdef CAM_RD_FIRST_MATCH_EN
  // Only the lowest match is ever delivered, so a flag and index are enough.
  logic                        r_pend_found;
  logic [ADDR_WIDTH_CAM-1:0]   r_pend_idx;

  // The encoder is only consulted in IDLE, directly on the live tag vector.
  assign w_enc_in       = tag_row;
  assign w_capture_last = r_pend_found;
  assign w_capture_addr = r_pend_idx;

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_pend_found <= 1'b0;
      r_pend_idx   <= '0;
    end else if (w_start_hit) begin
      r_pend_found <= 1'b1;
      r_pend_idx   <= w_enc_idx;
    end else if (w_capture) begin
      r_pend_found <= 1'b0;
    end
  end
`else
  logic [DATA_DEPTH-1:0]       r_pend;
  logic [DATA_DEPTH-1:0]       w_pend_cleared;

  // In IDLE the encoder looks at the live tag vector so the first row address
  // can be registered on the same edge that takes the snapshot; afterwards it
  // follows the snapshot.
  assign w_enc_in       = (r_state == CAM_RD_IDLE) ? tag_row : r_pend;
  // x & (x-1) drops the lowest set bit, i.e. the row being captured now.
  assign w_pend_cleared = r_pend & (r_pend - DATA_DEPTH'(1));
  assign w_capture_last = (w_pend_cleared == '0);
  assign w_capture_addr = r_addr;

  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_pend <= '0;
    end else if (w_start_hit) begin
      r_pend <= tag_row;
    end else if (w_capture) begin
      r_pend <= w_pend_cleared;
    end
  end
`endif

  cam_prio_enc #(
    .DEPTH (DATA_DEPTH),
    .IDX_W (ADDR_WIDTH_CAM)
  ) u_prio_enc (
    .i_vec   (w_enc_in),
    .o_idx   (w_enc_idx),
    .o_found (w_enc_found)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_state <= CAM_RD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CAM_RD_IDLE: begin
        if (start) begin
          w_state_next = w_enc_found ? CAM_RD_ISSUE : CAM_RD_DONE;
        end
      end
      CAM_RD_ISSUE:   w_state_next = CAM_RD_CAPTURE;
      CAM_RD_CAPTURE: w_state_next = CAM_RD_OUT;
      CAM_RD_OUT: begin
        if (r_m_valid && m_ready) begin
          w_state_next = r_m_last ? CAM_RD_DONE : CAM_RD_ISSUE;
        end
      end
      CAM_RD_DONE:    w_state_next = CAM_RD_IDLE;
      default:        w_state_next = CAM_RD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy        = (r_state != CAM_RD_IDLE);
    w_done        = (r_state == CAM_RD_DONE);
    // In IDLE the encoder found flag is the OR of the live tag vector.
    w_start_hit   = (r_state == CAM_RD_IDLE) && start && w_enc_found;
    w_start_empty = (r_state == CAM_RD_IDLE) && start && !w_enc_found;
    w_capture     = (r_state == CAM_RD_CAPTURE);
    w_handshake   = (r_state == CAM_RD_OUT) && r_m_valid && m_ready;
  end

  // ---------------------------------------------------------------------------
  // Row read address: valid throughout ISSUE and CAPTURE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_addr <= '0;
    end else if (w_start_hit || (w_handshake && !r_m_last)) begin
      r_addr <= w_enc_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Output beat register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_addr  <= '0;
      r_m_last  <= 1'b0;
    end else if (w_capture) begin
      r_m_valid <= 1'b1;
      r_m_data  <= Q_out_row;
      r_m_addr  <= w_capture_addr;
      r_m_last  <= w_capture_last;
    end else if (w_handshake) begin
      r_m_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rstIn) begin
    if (rstIn) begin
      r_no_match    <= 1'b0;
      r_match_count <= '0;
    end else if (w_start_hit || w_start_empty) begin
      r_no_match    <= w_start_empty;
      r_match_count <= '0;
    end else if (w_handshake && (r_match_count < MAX_COUNT)) begin
      r_match_count <= r_match_count + 1'b1;
    end
  end

  assign addr_output_Row = r_addr;
  assign m_valid         = r_m_valid;
  assign m_data          = r_m_data;
  assign m_addr          = r_m_addr;
  assign m_last          = r_m_last;
  assign busy            = w_busy;
  assign done            = w_done;
  assign no_match        = r_no_match;
  assign match_count     = r_match_count;

endmodule : cam_match_reader

// File: tb/tb_cam_match_reader.sv
// -----------------------------------------------------------------------------
// tb_cam_match_reader
// Directed, table-driven bench for cam_match_reader with a registered-read
// CAM row model. Define CAM_RD_FIRST_MATCH_EN for the first-match build.
// -----------------------------------------------------------------------------
module tb_cam_match_reader;

  localparam int DW = 8;
  localparam int DD = 16;
  localparam int AW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rstIn;
  logic          start;
  logic [DD-1:0] tag_row;
  logic [AW-1:0] addr_output_Row;
  logic [DW-1:0] Q_out_row;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          no_match;
  logic [AW:0]   match_count;

  always #5 clk = ~clk;

  cam_match_reader #(
    .DATA_WIDTH     (DW),
    .DATA_DEPTH     (DD),
    .ADDR_WIDTH_CAM (AW)
  ) dut (
    .clk             (clk),
    .rstIn           (rstIn),
    .start           (start),
    .tag_row         (tag_row),
    .addr_output_Row (addr_output_Row),
    .Q_out_row       (Q_out_row),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_addr          (m_addr),
    .m_last          (m_last),
    .busy            (busy),
    .done            (done),
    .no_match        (no_match),
    .match_count     (match_count)
  );

  // CAM row storage with a one-cycle registered read path
  logic [DW-1:0] row_mem [DD];
  always_ff @(posedge clk) Q_out_row <= row_mem[addr_output_Row[3:0]];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one full scan with optional first-beat stall and a mid-scan
  // start/tag change. Called just after an edge (+1) with the DUT idle.
  // ---------------------------------------------------------------------------
  task automatic run_scan(input logic [DD-1:0] tag, input logic [AW:0] exp_cnt,
                          input int stall, input bit mid_start);
    int            waited;
    int            beat;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_a;
    logic          hold_l;

    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < DD; i++) begin
      if (tag[i]) begin
`ifdef CAM_RD_FIRST_MATCH_EN
        if (exp_addr_q.size() == 0) begin
          exp_addr_q.push_back(AW'(i));
          exp_q.push_back(row_mem[i]);
        end
`else
        exp_addr_q.push_back(AW'(i));
        exp_q.push_back(row_mem[i]);
`endif
      end
    end

    m_ready = 1'b1;
    tag_row = tag;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;

    if (tag == '0) begin
      check("zero_done",     done,        1);
      check("zero_no_match", no_match,    1);
      check("zero_valid",    m_valid,     0);
      check("zero_count",    match_count, 0);
      @(posedge clk); #1;
      check("zero_done_drop", done, 0);
      check("zero_busy",      busy, 0);
      check("zero_valid2",    m_valid, 0);
      return;
    end

    check("start_busy",     busy,            1);
    check("start_no_match", no_match,        0);
    check("start_count",    match_count,     0);
    check("issue_addr",     addr_output_Row, exp_addr_q[0]);
    if (mid_start) tag_row = '1;

    beat = 0;
    while (exp_q.size() > 0) begin
      waited = 0;
      if (mid_start) start = 1'b1;
      while (!m_valid && waited < 20) begin
        @(posedge clk); #1;
        start = 1'b0;
        waited++;
      end
      if (!m_valid) begin
        check("beat_timeout", m_valid, 1);
        return;
      end
      check("beat_gap",  waited, 2);
      check("beat_addr", m_addr, exp_addr_q[0]);
      check("beat_data", m_data, exp_q[0]);
      check("beat_last", m_last, (exp_q.size() == 1));
      hold_d = m_data;
      hold_a = m_addr;
      hold_l = m_last;
      if (stall > 0 && beat == 0) begin
        m_ready = 1'b0;
        repeat (stall) begin
          @(posedge clk); #1;
          check("stall_valid", m_valid, 1);
          check("stall_data",  m_data,  hold_d);
          check("stall_addr",  m_addr,  hold_a);
          check("stall_last",  m_last,  hold_l);
          check("stall_count", match_count, 0);
        end
        m_ready = 1'b1;
      end
      void'(exp_q.pop_front());
      void'(exp_addr_q.pop_front());
      beat++;
      @(posedge clk); #1;
      check("hs_count",      match_count, beat);
      check("hs_valid_drop", m_valid,     0);
      if (exp_q.size() == 0) check("done_pulse", done, 1);
      else                   check("no_early_done", done, 0);
    end

    check("final_count", match_count, exp_cnt);
    @(posedge clk); #1;
    check("done_one_cycle", done,     0);
    check("idle_busy",      busy,     0);
    check("idle_no_match",  no_match, 0);
    if (mid_start) begin
      @(posedge clk); #1;
      check("stale_start_dropped", busy,    0);
      check("stale_start_valid",   m_valid, 0);
    end
    tag_row = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [DD-1:0] tag;
    logic [AW:0]   exp_cnt;
    int            stall;
    bit            mid_start;
  } vec_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    row_mem = '{8'h10, 8'h21, 8'hA5, 8'h47, 8'h5E, 8'h3C, 8'h66, 8'h7B,
                8'h81, 8'h9D, 8'hAA, 8'hB3, 8'hC8, 8'hD2, 8'hEF, 8'hF0};

    //          tag       count stall mid
    vecs[0] = '{16'h0000, 9'd0,  0, 1'b0}; // empty snapshot
    vecs[1] = '{16'h0024, 9'd2,  0, 1'b0}; // rows 2 and 5, no backpressure
    vecs[2] = '{16'h0024, 9'd2,  4, 1'b0}; // first beat stalled 4 cycles
    vecs[3] = '{16'h0024, 9'd2,  0, 1'b1}; // tag -> FFFF and start mid-scan
    vecs[4] = '{16'hFFFF, 9'd16, 0, 1'b0}; // every row, count reaches depth
    vecs[5] = '{16'h8081, 9'd3,  0, 1'b0}; // rows 0, 7, 15
    vecs[6] = '{16'h8000, 9'd1,  2, 1'b0}; // top row only, stalled
    vecs[7] = '{16'h1248, 9'd4,  0, 1'b0}; // rows 3, 6, 9, 12
`ifdef CAM_RD_FIRST_MATCH_EN
    for (int v = 0; v < NVEC; v++) vecs[v].exp_cnt = (vecs[v].tag != '0) ? 9'd1 : 9'd0;
`endif

    // Reset
    rstIn   = 1'b1;
    start   = 1'b0;
    tag_row = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",     addr_output_Row, 0);
    check("rst_valid",    m_valid,         0);
    check("rst_data",     m_data,          0);
    check("rst_maddr",    m_addr,          0);
    check("rst_last",     m_last,          0);
    check("rst_busy",     busy,            0);
    check("rst_done",     done,            0);
    check("rst_no_match", no_match,        0);
    check("rst_count",    match_count,     0);
    rstIn = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < NVEC; v++) begin
      run_scan(vecs[v].tag, vecs[v].exp_cnt, vecs[v].stall, vecs[v].mid_start);
      @(posedge clk); #1;
    end

    // Asynchronous reset while the first beat waits in OUT
    m_ready = 1'b0;
    tag_row = 16'h0024;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    waited  = 0;
    while (!m_valid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("arst_pre_valid", m_valid,         1);
    check("arst_pre_addr",  addr_output_Row, 2);
    #2 rstIn = 1'b1;
    #1;
    check("arst_addr",     addr_output_Row, 0);
    check("arst_valid",    m_valid,         0);
    check("arst_data",     m_data,          0);
    check("arst_maddr",    m_addr,          0);
    check("arst_last",     m_last,          0);
    check("arst_busy",     busy,            0);
    check("arst_done",     done,            0);
    check("arst_no_match", no_match,        0);
    check("arst_count",    match_count,     0);
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_hold_done", done, 0);
      check("arst_hold_busy", busy, 0);
    end
    rstIn = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", done, 0);
    run_scan(16'h0001, 9'd1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cam_match_reader
